rf_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the 8x8-bit register file. It shares the file's single write port (wrEn/rd/dIn) between two write-back requesters, the ALU (req0) and the load unit (req1), using round-robin arbitration. It also tracks a busy bit per register so issue logic can stall on RAW hazards. It sits between the execute/memory stages and the register file.

---
 rtl/rf_wb_arbiter.sv | 177 +++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//
// Write-back arbiter and busy-bit scoreboard for the 8x8-bit register file.
// Two write-back requesters share the register file's single write port:
// the ALU (req0) and the load unit (req1). A one-bit round-robin pointer picks
// between them. A per-register busy bit lets issue logic stall on RAW hazards.
//
// Ports
//   clk, rst             clock; asynchronous active-low reset
//   req0Valid/Rd/Data    ALU write-back request
//   req0Ready            ALU request granted this cycle (combinational)
//   req1Valid/Rd/Data    load-unit write-back request
//   req1Ready            load request granted this cycle (combinational)
//   issueEn, issueRd     an instruction issued; mark issueRd busy
//   rs1, rs2             source-register hazard queries
//   rs1Busy, rs2Busy     busy[rs1] / busy[rs2] (combinational, no bypass)
//   busyVec              full scoreboard state
//   wrEn, rd, dIn        registered register-file write port
//
// Handshake: a request transfers on a cycle where Valid and Ready are both
// high at the rising edge. Ready is only ever high when the matching Valid is
// high, and at most one Ready is high per cycle. Requesters must not make
// Valid depend on Ready; Ready depends combinationally on both Valids.
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0Valid,
  input  logic [ADDR_W-1:0]   req0Rd,
  input  logic [DATA_W-1:0]   req0Data,
  output logic                req0Ready,
  input  logic                req1Valid,
  input  logic [ADDR_W-1:0]   req1Rd,
  input  logic [DATA_W-1:0]   req1Data,
  output logic                req1Ready,
  input  logic                issueEn,
  input  logic [ADDR_W-1:0]   issueRd,
  input  logic [ADDR_W-1:0]   rs1,
  input  logic [ADDR_W-1:0]   rs2,
  output logic                rs1Busy,
  output logic                rs2Busy,
  output logic [NUM_REGS-1:0] busyVec,
  output logic                wrEn,
  output logic [ADDR_W-1:0]   rd,
  output logic [DATA_W-1:0]   dIn
);

  // Round-robin pointer encoding: which requester wins when both are valid.
  localparam logic PREF_REQ0 = 1'b0;
  localparam logic PREF_REQ1 = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                pref_q,  pref_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   rd_q,    rd_d;
  logic [DATA_W-1:0]   data_q,  data_d;
  logic [NUM_REGS-1:0] busy_q,  busy_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic grant0;
  logic grant1;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0Valid && req1Valid) begin
      grant0 = (pref_q == PREF_REQ0);
      grant1 = (pref_q == PREF_REQ1);
    end else begin
      grant0 = req0Valid;
      grant1 = req1Valid;
    end
  end

  assign req0Ready = grant0;
  assign req1Ready = grant1;

  // After any grant the other requester becomes preferred, so a requester
  // that keeps Valid high loses at most one arbitration in a row.
  always_comb begin
    pref_d = pref_q;
    if (grant0) begin
      pref_d = PREF_REQ1;
    end else if (grant1) begin
      pref_d = PREF_REQ0;
    end
  end

  // ---------------------------------------------------------------------------
  // Write-port output stage: one cycle from grant to register-file commit.
  // rd/dIn hold on idle cycles; only wrEn qualifies them.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_en_d = grant0 | grant1;
    rd_d    = rd_q;
    data_d  = data_q;
    if (grant0) begin
      rd_d   = req0Rd;
      data_d = req0Data;
    end else if (grant1) begin
      rd_d   = req1Rd;
      data_d = req1Data;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // A busy bit clears on the edge where the register file commits the write
  // (wr_en_q/rd_q), so the register reads not-busy exactly when the file holds
  // the new value. A set of the same register on that edge wins: it belongs to
  // a newer producer that is still in flight.
  // ---------------------------------------------------------------------------
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issueEn) begin
      set_vec = NUM_REGS'(1) << issueRd;
    end
    if (wr_en_q) begin
      clr_vec = NUM_REGS'(1) << rd_q;
    end
    busy_d = set_vec | (busy_q & ~clr_vec);
  end

  // ---------------------------------------------------------------------------
  // Flops
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pref_q  <= PREF_REQ0;
      wr_en_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      busy_q  <= '0;
    end else begin
      pref_q  <= pref_d;
      wr_en_q <= wr_en_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign wrEn    = wr_en_q;
  assign rd      = rd_q;
  assign dIn     = data_q;
  assign busyVec = busy_q;
  assign rs1Busy = busy_q[rs1];
  assign rs2Busy = busy_q[rs2];

  // ---------------------------------------------------------------------------
  // Handshake invariants
  // ---------------------------------------------------------------------------
  a_ready0_needs_valid : assert property (
    @(posedge clk) disable iff (!rst) req0Ready |-> req0Valid);
  a_ready1_needs_valid : assert property (
    @(posedge clk) disable iff (!rst) req1Ready |-> req1Valid);
  a_single_grant : assert property (
    @(posedge clk) disable iff (!rst) !(req0Ready && req1Ready));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
`timescale 1ns/1ps
module tb_rf_wb_arbiter;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;
  localparam int W        = ADDR_W + DATA_W;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                req0Valid, req1Valid, issueEn;
  logic [ADDR_W-1:0]   req0Rd, req1Rd, issueRd, rs1, rs2;
  logic [DATA_W-1:0]   req0Data, req1Data;
  logic                req0Ready, req1Ready, rs1Busy, rs2Busy, wrEn;
  logic [NUM_REGS-1:0] busyVec;
  logic [ADDR_W-1:0]   rd;
  logic [DATA_W-1:0]   dIn;

  rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst),
    .req0Valid(req0Valid), .req0Rd(req0Rd), .req0Data(req0Data), .req0Ready(req0Ready),
    .req1Valid(req1Valid), .req1Rd(req1Rd), .req1Data(req1Data), .req1Ready(req1Ready),
    .issueEn(issueEn), .issueRd(issueRd),
    .rs1(rs1), .rs2(rs2), .rs1Busy(rs1Busy), .rs2Busy(rs2Busy),
    .busyVec(busyVec), .wrEn(wrEn), .rd(rd), .dIn(dIn)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_busy(input logic [NUM_REGS-1:0] exp);
    chk("busyVec", 32'(busyVec), 32'(exp));
    chk("rs1Busy", 32'(rs1Busy), 32'(exp[rs1]));
    chk("rs2Busy", 32'(rs2Busy), 32'(exp[rs2]));
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // Inputs change at the falling edge; Ready is sampled 1ns later. Every
  // expected grant pushes its {rd, data} for the monitor.
  // ---------------------------------------------------------------------------
  task automatic step(input logic v0, input logic [ADDR_W-1:0] r0, input logic [DATA_W-1:0] d0,
                      input logic v1, input logic [ADDR_W-1:0] r1, input logic [DATA_W-1:0] d1,
                      input logic ie, input logic [ADDR_W-1:0] ir,
                      input logic e0, input logic e1);
    @(negedge clk);
    req0Valid = v0; req0Rd = r0; req0Data = d0;
    req1Valid = v1; req1Rd = r1; req1Data = d1;
    issueEn   = ie; issueRd = ir;
    #1;
    chk("req0Ready", 32'(req0Ready), 32'(e0));
    chk("req1Ready", 32'(req1Ready), 32'(e1));
    if (e0)      exp_q.push_back({r0, d0});
    else if (e1) exp_q.push_back({r1, d1});
  endtask

  task automatic idle(input logic ie, input logic [ADDR_W-1:0] ir);
    step(1'b0, '0, '0, 1'b0, '0, '0, ie, ir, 1'b0, 1'b0);
  endtask

  task automatic clear_inputs();
    req0Valid = 1'b0; req0Rd = '0; req0Data = '0;
    req1Valid = 1'b0; req1Rd = '0; req1Data = '0;
    issueEn   = 1'b0; issueRd = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: any write queued one cycle earlier must be on the port now;
  // with nothing queued the port must be idle.
  // ---------------------------------------------------------------------------
  logic [W-1:0] mon_e;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("wrEn", 32'(wrEn), 32'd1);
        chk("rd",   32'(rd),   32'(mon_e[W-1:DATA_W]));
        chk("dIn",  32'(dIn),  32'(mon_e[DATA_W-1:0]));
      end else begin
        chk("wrEn_idle", 32'(wrEn), 32'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    clear_inputs();
    rs1 = 3'd5;
    rs2 = 3'd6;

    // Reset then idle
    #1 rst = 1'b0;
    #1;
    chk("rst_wrEn", 32'(wrEn), 32'd0);
    chk("rst_rd",   32'(rd),   32'd0);
    chk("rst_dIn",  32'(dIn),  32'd0);
    chk("rst_req0Ready", 32'(req0Ready), 32'd0);
    chk("rst_req1Ready", 32'(req1Ready), 32'd0);
    chk_busy(8'h00);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) begin
      idle(1'b0, '0);
      chk_busy(8'h00);
    end

    // Single requester: grant now, write next cycle, then idle
    step(1'b1, 3'd3, 8'h5A, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    idle(1'b0, '0);
    idle(1'b0, '0);

    // Lone req1 (pointer had moved to req1 after the req0 grant; now back to req0)
    step(1'b0, '0, '0, 1'b1, 3'd4, 8'h44, 1'b0, '0, 1'b0, 1'b1);

    // Contention: alternate req0, req1, req0, req1
    step(1'b1, 3'd1, 8'hF1, 1'b1, 3'd2, 8'hFA, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 3'd1, 8'hF1, 1'b1, 3'd2, 8'hFA, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 3'd1, 8'hF1, 1'b1, 3'd2, 8'hFA, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 3'd1, 8'hF1, 1'b1, 3'd2, 8'hFA, 1'b0, '0, 1'b0, 1'b1);
    idle(1'b0, '0);
    chk_busy(8'h00);

    // Scoreboard: issue r5, req1 writes r5, busy until commit edge
    idle(1'b1, 3'd5);
    chk_busy(8'h00);
    step(1'b0, '0, '0, 1'b1, 3'd5, 8'hA5, 1'b0, '0, 1'b0, 1'b1);
    chk_busy(8'h20);
    idle(1'b0, '0);
    chk_busy(8'h20);
    idle(1'b0, '0);
    chk_busy(8'h00);

    // Simultaneous set and clear of r6: set wins
    step(1'b1, 3'd6, 8'h66, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    chk_busy(8'h00);
    idle(1'b1, 3'd6);
    chk_busy(8'h00);
    idle(1'b0, '0);
    chk_busy(8'h40);

    // Clear r6 while setting r7 on the same edge (independent registers)
    step(1'b1, 3'd6, 8'h60, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    chk_busy(8'h40);
    idle(1'b1, 3'd7);
    chk_busy(8'h40);

    // Reset mid-write: r7 granted with busyVec = 8'h80
    step(1'b1, 3'd7, 8'h07, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    chk_busy(8'h80);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();
    exp_q.delete();
    #1;
    chk("midrst_wrEn", 32'(wrEn), 32'd0);
    chk("midrst_rd",   32'(rd),   32'd0);
    chk("midrst_dIn",  32'(dIn),  32'd0);
    chk_busy(8'h00);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      idle(1'b0, '0);
      chk_busy(8'h00);
    end

    // Pointer is back to req0-preferred after reset
    step(1'b1, 3'd1, 8'hF1, 1'b1, 3'd2, 8'hFA, 1'b0, '0, 1'b1, 1'b0);
    idle(1'b0, '0);
    idle(1'b0, '0);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Bound on total run time
  initial begin
    #100000;
    $display("FAIL timeout: run did not complete, expected finish before 100000ns");
    $fatal(1, "timeout");
  end

endmodule
